// File: rtl/wb_stage_hs_pkg.sv
// Shared definitions for the writeback stage.
//   result_src_e : result source select encodings
//   F3_*         : load funct3 codes
//   wb_entry_t   : writeback entry layout {regwrite, rd, wdata} at the default
//                  core widths (XLEN=32, REG_AW=5)
//   occ_state_e  : occupancy of the output/skid pipeline
package core_pkg;

  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_LOAD = 2'b01,
    RS_PC4  = 2'b10,
    RS_IMM  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } occ_state_e;

endpackage

// File: rtl/wb_stage_hs_load_align.sv
// load_align: combinational load formatter.
//   data   : raw aligned memory word
//   off    : byte offset within the word (low address bits)
//   funct3 : load size/sign code
//   result : extracted and sign/zero-extended load value
// LWU/LD only exist for XLEN=64; for XLEN=32 they pass data through unchanged.
module load_align
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]              data,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic [2:0]                   funct3,
  output logic [XLEN-1:0]              result
);

  localparam int unsigned OW = $clog2(XLEN/8);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] wordSel;

  assign byteSel = data[8*off +: 8];
  assign halfSel = data[16*off[OW-1:1] +: 16];

  generate
    if (XLEN == 64) begin : gWord64
      assign wordSel = data[32*off[OW-1] +: 32];
    end else begin : gWord32
      assign wordSel = data[31:0];
    end
  endgenerate

  always_comb begin
    result = data;
    case (funct3)
      F3_LB:  result = XLEN'($signed(byteSel));
      F3_LBU: result = XLEN'(byteSel);
      F3_LH:  result = XLEN'($signed(halfSel));
      F3_LHU: result = XLEN'(halfSel);
      F3_LW:  if (XLEN == 64) result = XLEN'($signed(wordSel));
      F3_LWU: if (XLEN == 64) result = XLEN'(wordSel);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/wb_stage_hs.sv
// wb_stage_hs: writeback stage with valid/ready input, result mux, load
// formatting and a 2-deep (out + skid) pipeline toward the register file.
//   clk, rst (sync, active-high)
//   in_*      : retiring instruction from MEM (in_valid/in_ready handshake)
//   rf_*      : register-file write port (rf_valid/rf_ready handshake),
//               rf_we suppressed for x0 or regwrite=0
//   fwd_*     : WB->EX bypass of the out register; only driven when the
//               macro WB_FWD_EN is defined, otherwise tied to 0
//   instret   : retired instruction count (wraps)
module wb_stage_hs
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic [1:0]        in_result_src,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_read_data,
  input  logic [XLEN-1:0]   in_pc_plus4,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [2:0]        in_funct3,
  input  logic [REG_AW-1:0] in_rd,
  output logic              rf_valid,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic [CNT_W-1:0]  instret
);

  // Same layout as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              regwrite;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wdata;
  } entry_t;

  occ_state_e state, stateNext;
  entry_t     outE, skidE, inE;

  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] resultMux;
  logic            accept, retire, rfValidInt;
  logic            loadOut, loadSkid, skidToOut;

  load_align #(.XLEN(XLEN)) uLoadAlign (
    .data   (in_read_data),
    .off    (in_alu_result[$clog2(XLEN/8)-1:0]),
    .funct3 (in_funct3),
    .result (loadData)
  );

  always_comb begin
    resultMux = in_alu_result;
    case (result_src_e'(in_result_src))
      RS_ALU:  resultMux = in_alu_result;
      RS_LOAD: resultMux = loadData;
      RS_PC4:  resultMux = in_pc_plus4;
      RS_IMM:  resultMux = in_imm;
      default: resultMux = in_alu_result;
    endcase
  end

  assign inE = '{regwrite: in_regwrite, rd: in_rd, wdata: resultMux};

  // Masking with rst keeps the port quiet during the reset cycle itself,
  // before the synchronous clear has taken effect.
  assign rfValidInt = (state != ST_EMPTY) && !rst;
  assign in_ready   = (state != ST_TWO);
  assign accept     = in_valid && in_ready;
  assign retire     = rfValidInt && rf_ready;

  assign rf_valid = rfValidInt;
  assign rf_we    = rfValidInt && outE.regwrite && (outE.rd != '0);
  assign rf_rd    = outE.rd;
  assign rf_wdata = outE.wdata;

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_rd    = outE.rd;
  assign fwd_data  = outE.wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

  always_comb begin
    stateNext = state;
    loadOut   = 1'b0;
    loadSkid  = 1'b0;
    skidToOut = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          stateNext = ST_ONE;
          loadOut   = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && retire) begin
          loadOut = 1'b1;
        end else if (accept) begin
          stateNext = ST_TWO;
          loadSkid  = 1'b1;
        end else if (retire) begin
          stateNext = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (retire) begin
          stateNext = ST_ONE;
          skidToOut = 1'b1;
        end
      end
      default: stateNext = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_EMPTY;
      outE    <= '0;
      skidE   <= '0;
      instret <= '0;
    end else begin
      state <= stateNext;
      if (loadOut) begin
        outE <= inE;
      end else if (skidToOut) begin
        outE <= skidE;
      end
      if (loadSkid) begin
        skidE <= inE;
      end
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_hs.sv
module tb_wb_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic [1:0]  in_result_src;
  logic [31:0] in_alu_result;
  logic [31:0] in_read_data;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_imm;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        rf_valid;
  logic        rf_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [63:0] instret;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;

  sb_t         sbQ[$];
  int          testCount = 0;
  int          failCount = 0;
  logic [63:0] expInstret = '0;

  wb_stage_hs #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_regwrite   (in_regwrite),
    .in_result_src (in_result_src),
    .in_alu_result (in_alu_result),
    .in_read_data  (in_read_data),
    .in_pc_plus4   (in_pc_plus4),
    .in_imm        (in_imm),
    .in_funct3     (in_funct3),
    .in_rd         (in_rd),
    .rf_valid      (rf_valid),
    .rf_ready      (rf_ready),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [1:0] src, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [31:0] imm, input logic [2:0] f3,
                         input logic [4:0] rd, input logic rw);
    in_valid      = 1'b1;
    in_result_src = src;
    in_alu_result = alu;
    in_read_data  = rdata;
    in_pc_plus4   = pc4;
    in_imm        = imm;
    in_funct3     = f3;
    in_rd         = rd;
    in_regwrite   = rw;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] src, input logic [31:0] alu, input logic [31:0] rdata,
                      input logic [31:0] pc4, input logic [31:0] imm, input logic [2:0] f3,
                      input logic [4:0] rd, input logic rw, input logic [31:0] expData,
                      input bit track);
    bit   accepted;
    sb_t  e;
    accepted = 1'b0;
    present(src, alu, rdata, pc4, imm, f3, rd, rw);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (accepted) begin
      if (track) begin
        e.we   = rw && (rd != 5'd0);
        e.rd   = rd;
        e.data = expData;
        sbQ.push_back(e);
      end
      @(posedge clk);
      #1;
    end else begin
      chk("send_timeout", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!rf_valid && sbQ.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard monitor: a retire happens at the next rising edge.
  always @(negedge clk) begin
    sb_t e;
    if (!rst && rf_valid && rf_ready) begin
      if (sbQ.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sbQ.pop_front();
        chk("rf_we", 64'(rf_we), 64'(e.we));
        chk("rf_rd", 64'(rf_rd), 64'(e.rd));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
        expInstret = expInstret + 64'd1;
      end
`ifndef WB_FWD_EN
      chk("fwd_valid_off", 64'(fwd_valid), 64'd0);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rf_ready = 1'b1;
    in_valid = 1'b0;
    present(2'b00, '0, '0, '0, '0, 3'b000, 5'd0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rf_valid", 64'(rf_valid), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_rd", 64'(rf_rd), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_instret", instret, 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);

    // Backpressure: A held, B in skid, C stalls, then A,B,C drain in order.
    @(posedge clk); #1;
    rf_ready = 1'b0;
    send(2'b00, 32'h0000_00A1, '0, '0, '0, 3'b000, 5'd1, 1'b1, 32'h0000_00A1, 1'b1);
    send(2'b00, 32'h0000_00B2, '0, '0, '0, 3'b000, 5'd2, 1'b1, 32'h0000_00B2, 1'b1);
    present(2'b00, 32'h0000_00C3, '0, '0, '0, 3'b000, 5'd3, 1'b1);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_valid", 64'(rf_valid), 64'd1);
    chk("bp_hold_rd", 64'(rf_rd), 64'd1);
    chk("bp_hold_data", 64'(rf_wdata), 64'h0000_00A1);
    repeat (2) @(negedge clk);
    chk("bp_still_stalled", 64'(in_ready), 64'd0);
    chk("bp_still_rd", 64'(rf_rd), 64'd1);
    @(posedge clk); #1;
    rf_ready = 1'b1;
    send(2'b00, 32'h0000_00C3, '0, '0, '0, 3'b000, 5'd3, 1'b1, 32'h0000_00C3, 1'b1);
    drain();
    chk("bp_instret", instret, 64'd3);

    // Source mux
    @(posedge clk); #1;
    send(2'b10, 32'h0000_0055, '0, 32'h0000_0104, 32'h1111_1111, 3'b000, 5'd6, 1'b1, 32'h0000_0104, 1'b1);
    send(2'b11, 32'h0000_0055, '0, 32'h0000_0104, 32'h1234_5000, 3'b000, 5'd7, 1'b1, 32'h1234_5000, 1'b1);
    send(2'b00, 32'hCAFE_F00D, '0, '0, '0, 3'b000, 5'd8, 1'b0, 32'hCAFE_F00D, 1'b1);

    // Load formatting, read_data = 0x80FF7F01
    send(2'b01, 32'h0000_1003, 32'h80FF_7F01, '0, '0, 3'b000, 5'd9,  1'b1, 32'hFFFF_FF80, 1'b1);
    send(2'b01, 32'h0000_1001, 32'h80FF_7F01, '0, '0, 3'b100, 5'd10, 1'b1, 32'h0000_007F, 1'b1);
    send(2'b01, 32'h0000_1002, 32'h80FF_7F01, '0, '0, 3'b001, 5'd11, 1'b1, 32'hFFFF_80FF, 1'b1);
    send(2'b01, 32'h0000_1000, 32'h80FF_7F01, '0, '0, 3'b010, 5'd12, 1'b1, 32'h80FF_7F01, 1'b1);
    send(2'b01, 32'h0000_1002, 32'h80FF_7F01, '0, '0, 3'b101, 5'd13, 1'b1, 32'h0000_80FF, 1'b1);
    send(2'b01, 32'h0000_1000, 32'h80FF_7F01, '0, '0, 3'b000, 5'd14, 1'b1, 32'h0000_0001, 1'b1);
    send(2'b01, 32'h0000_1002, 32'h80FF_7F01, '0, '0, 3'b000, 5'd15, 1'b1, 32'hFFFF_FFFF, 1'b1);
    send(2'b01, 32'h0000_1000, 32'h80FF_7F01, '0, '0, 3'b001, 5'd16, 1'b1, 32'h0000_7F01, 1'b1);
    send(2'b01, 32'h0000_1001, 32'h80FF_7F01, '0, '0, 3'b011, 5'd17, 1'b1, 32'h80FF_7F01, 1'b1);

    // x0 write: occupies the pipeline, no write enable, still counted
    send(2'b00, 32'h0000_1234, '0, '0, '0, 3'b000, 5'd0, 1'b1, 32'h0000_1234, 1'b1);
    drain();
    chk("x0_instret", instret, expInstret);
    chk("x0_instret_abs", instret, 64'd16);

    // Forwarding with the output held; second entry goes to the skid
    @(posedge clk); #1;
    rf_ready = 1'b0;
    send(2'b00, 32'hDEAD_BEEF, '0, '0, '0, 3'b000, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b1);
    send(2'b00, 32'h0BAD_F00D, '0, '0, '0, 3'b000, 5'd6, 1'b1, 32'h0BAD_F00D, 1'b1);
    @(negedge clk);
    chk("fwd_hold_valid", 64'(rf_valid), 64'd1);
`ifdef WB_FWD_EN
    chk("fwd_valid", 64'(fwd_valid), 64'd1);
    chk("fwd_rd", 64'(fwd_rd), 64'd5);
    chk("fwd_data", 64'(fwd_data), 64'hDEAD_BEEF);
`else
    chk("fwd_valid_tied", 64'(fwd_valid), 64'd0);
    chk("fwd_rd_tied", 64'(fwd_rd), 64'd0);
    chk("fwd_data_tied", 64'(fwd_data), 64'd0);
`endif
    @(posedge clk); #1;
    rf_ready = 1'b1;
    drain();
    chk("fwd_instret", instret, expInstret);

    // Mid-stream reset while in TWO
    @(posedge clk); #1;
    rf_ready = 1'b0;
    send(2'b00, 32'h0000_0D0D, '0, '0, '0, 3'b000, 5'd20, 1'b1, 32'h0000_0D0D, 1'b0);
    send(2'b00, 32'h0000_0E0E, '0, '0, '0, 3'b000, 5'd21, 1'b1, 32'h0000_0E0E, 1'b0);
    @(negedge clk);
    chk("mrst_two_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    rf_ready = 1'b1;
    expInstret = '0;
    @(negedge clk);
    chk("mrst_cycle_we", 64'(rf_we), 64'd0);
    chk("mrst_cycle_valid", 64'(rf_valid), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_after_valid", 64'(rf_valid), 64'd0);
    chk("mrst_after_we", 64'(rf_we), 64'd0);
    chk("mrst_after_instret", instret, 64'd0);
    chk("mrst_after_ready", 64'(in_ready), 64'd1);

    @(posedge clk); #1;
    send(2'b00, 32'h0000_0F0F, '0, '0, '0, 3'b000, 5'd22, 1'b1, 32'h0000_0F0F, 1'b1);
    drain();
    chk("post_rst_instret", instret, 64'd1);
    chk("sb_empty", 64'(sbQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_stage_hs.md
Name: wb_stage_hs

Overview:
- Parametrised successor of the 5-stage core's writeback cycle.
- Accepts retiring instructions from MEM over a valid/ready handshake and selects one of four result sources.
- Formats load data by funct3 and byte offset: sign or zero extension, byte/half/word/dword.
- Registers the result into a 2-deep skid pipeline toward a stallable register-file write port, suppresses x0 writes and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register index width.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  stage can accept; equals !(state==TWO)
- in_regwrite  in  1  instruction writes rd
- in_result_src  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- in_alu_result  in  XLEN  ALU result, also the load address
- in_read_data  in  XLEN  raw aligned memory word
- in_pc_plus4  in  XLEN  PC+4
- in_imm  in  XLEN  U-type immediate
- in_funct3  in  3  load size/sign
- in_rd  in  REG_AW  destination
- rf_valid  out  1  output entry valid
- rf_ready  in  1  register file accepts this cycle
- rf_we  out  1  rf_valid & regwrite & rd!=0
- rf_rd  out  REG_AW  destination
- rf_wdata  out  XLEN  result
- fwd_valid  out  1  forwarding valid (optional feature)
- fwd_rd  out  REG_AW  forwarding rd
- fwd_data  out  XLEN  forwarding data
- instret  out  CNT_W  retired count

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - On rst: state=EMPTY, rf_valid=0, rf_we=0, rf_rd=0, rf_wdata=0, fwd_*=0, instret=0.
- Accept and retire:
  - accept = in_valid & in_ready.
  - retire = rf_valid & rf_ready.
- Result mux (combinational, at input):
  - 00: in_alu_result
  - 01: formatted load
  - 10: in_pc_plus4
  - 11: in_imm
- Load formatting:
  - OFF = in_alu_result[log2(XLEN/8)-1:0].
  - Byte extraction: byte = data[8*OFF +: 8].
  - Half extraction: half = data[16*OFF[..:1] +: 16].
  - Word extraction (XLEN=64): word = data[32*OFF[2] +: 32].
  - funct3 000 LB sext, 100 LBU zext, 001 LH sext, 101 LHU zext.
  - funct3 010 LW: sext when XLEN=64, identity when 32.
  - funct3 110 LWU, 011 LD: XLEN=64 only.
  - Any other code: raw in_read_data.
- Latency: accept to rf_valid is one cycle when the pipeline is EMPTY, or when in ONE and retiring that cycle.
- State machine (occupancy: out register plus skid register):
  - EMPTY: accept -> ONE (load out).
  - ONE:
    - accept & retire -> ONE (out replaced).
    - accept & !retire -> TWO (skid loaded).
    - !accept & retire -> EMPTY.
    - otherwise hold.
  - TWO: in_ready=0; retire -> ONE (skid moves to out); else hold.
- Output stability: out fields hold stable while rf_valid & !rf_ready.
- x0 suppression: rd==0 or regwrite==0 gives rf_we=0, but the entry still occupies the pipeline and is counted at retire.
- instret: increments by 1 per retire and wraps at 2^CNT_W.
- Mid-operation reset: rst in any state discards both entries; no write issues in the reset cycle or the following cycle.

Optional Feature:
- Macro WB_FWD_EN.
- Defined:
  - fwd_valid = rf_we of the out register.
  - fwd_rd and fwd_data mirror out register contents, for the hazard unit's WB→EX bypass.
  - When state==TWO, forwarding still reflects the out register (older entry); the skid is not forwarded.
- Undefined: fwd_valid, fwd_rd and fwd_data are tied to 0.

Decomposition:
- Shared package core_pkg holds:
  - RESULT_SRC encodings (RS_ALU, RS_LOAD, RS_PC4, RS_IMM).
  - LOAD funct3 constants.
  - A wb_entry_t struct {regwrite, rd, wdata}.
- Sub-module load_align (XLEN parameter) contains the purely combinational load formatter.

Test Plan:
- Reset: hold rst 2 cycles mid-stream with state TWO -> rf_valid=0, instret=0, in_ready=1 on the next cycle.
- Load formatting (XLEN=32): read_data=0x80FF7F01.
  - LB, off=3 -> 0xFFFFFF80.
  - LBU, off=1 -> 0x0000007F.
  - LH, off=2 -> 0xFFFF80FF.
  - LW -> 0x80FF7F01.
- Backpressure:
  - rf_ready=0, stream A(rd=1), B(rd=2), C(rd=3) -> A held, B in skid, in_ready=0, C stalls.
  - rf_ready=1 -> A, B, C written in order on consecutive cycles; instret=3.
- x0 write: rd=0, regwrite=1, src=ALU, 0x1234 -> rf_valid=1, rf_we=0, instret increments.
- Source mux: src=10, pc_plus4=0x104 -> rf_wdata=0x104; src=11, imm=0x12345000 -> 0x12345000.
- WB_FWD_EN:
  - Defined: with the output held (rf_ready=0), fwd_rd=5 and fwd_data=0xDEADBEEF while rf_valid.
  - Undefined: fwd_valid=0 always.
